// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver, the transmitter and the baud clock generator.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic hwclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, one-cycle valid / frame_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      hwclk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  uart_state_e               state;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] sr;
  logic                      rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .hwclk (hwclk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge hwclk) begin
    valid     <= 1'b0;
    frame_err <= 1'b0;
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
      data  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!rx_s) begin
          state <= ST_START;
          cnt   <= CW'(HALF - 1);
          busy  <= 1'b1;
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            state <= ST_DATA;
            idx   <= '0;
            cnt   <= CW'(CLKS_PER_BIT - 1);
          end else begin
            // start bit vanished before mid-bit: a glitch, not a frame
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            sr  <= {rx_s, sr[UART_DATA_BITS-1:1]};
            cnt <= CW'(CLKS_PER_BIT - 1);
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            data  <= sr;
            valid <= 1'b1;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_BREAK;
          end
        end
        ST_BREAK: if (rx_s) begin
          // a held-low line must go high before another start edge is accepted
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
